ship_datapath: RTL and testbench

Ship-side datapath that responds to the game control FSM's per-state enables. It owns the player ship's position, health, invulnerability window, fire requests and the game-over LED animation. Its `ship_health` output is the status the control FSM watches to enter game over. It sits between the control FSM, the DE2 pushbuttons and the grid/collision logic, and feeds ship coordinates to the VGA draw path.

---
 rtl/starflux_pkg.sv | 19 +
 rtl/ship_datapath_if.sv | 35 +++
 rtl/rate_divider.sv | 27 ++
 rtl/ship_datapath.sv | 150 +++++++++++++++
 tb/tb_ship_datapath.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/starflux_pkg.sv
// starflux_pkg
// Shared constants and types for the game: screen limits, ship health width
// and reset value, and the encoding of the ship datapath's mode.
// No ports (package).
package starflux_pkg;

  localparam int X_MAX = 159;
  localparam int Y_MAX = 119;

  localparam int HEALTH_W = 8;
  localparam logic [HEALTH_W-1:0] HEALTH_INIT = 8'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_DEAD = 2'd2
  } ship_mode_t;

endpackage

// File: rtl/ship_datapath_if.sv
// ship_datapath_if
// Bundles the control FSM enables, the pushbuttons, the collision level and
// the ship status returned to the control FSM / VGA draw path.
//   master : control side (drives enables, buttons, hit; reads ship status)
//   slave  : ship datapath (reads enables, buttons, hit; drives ship status)
interface ship_datapath_if;
  import starflux_pkg::*;

  logic                startGameEn;
  logic                shipUpdateEn;
  logic                gameOverEn;
  logic                btn_left;
  logic                btn_right;
  logic                btn_fire;
  logic                hit;
  logic [7:0]          ship_x;
  logic [6:0]          ship_y;
  logic [HEALTH_W-1:0] ship_health;
  logic                fire_req;
  logic                invuln;
  logic [7:0]          led_pattern;

  modport master (
    output startGameEn, shipUpdateEn, gameOverEn,
    output btn_left, btn_right, btn_fire, hit,
    input  ship_x, ship_y, ship_health, fire_req, invuln, led_pattern
  );

  modport slave (
    input  startGameEn, shipUpdateEn, gameOverEn,
    input  btn_left, btn_right, btn_fire, hit,
    output ship_x, ship_y, ship_health, fire_req, invuln, led_pattern
  );

endinterface

// File: rtl/rate_divider.sv
// rate_divider
// Down-counter that reloads from countdown_start whenever enable is low and
// after reaching zero, so q==0 marks one tick every countdown_start+1 cycles.
//   clk, resetn     : clock, synchronous active-low reset
//   enable          : count while high, hold reloaded while low
//   countdown_start : reload value
//   q               : current count
module rate_divider #(
  parameter int WIDTH = 28
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             enable,
  input  logic [WIDTH-1:0] countdown_start,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (!resetn)
      q <= countdown_start;
    else if (!enable || q == '0)
      q <= countdown_start;
    else
      q <= q - 1'b1;
  end

endmodule

// File: rtl/ship_datapath.sv
// ship_datapath
// Player ship state driven by the control FSM's enables: position, health,
// post-hit immunity window, fire requests and the game-over LED animation.
//   clk, resetn : 50 MHz clock, synchronous active-low reset
//   bus (slave) : enables, buttons, hit in; ship_x/y, ship_health, fire_req,
//                 invuln, led_pattern out
module ship_datapath
  import starflux_pkg::*;
#(
  parameter int                  X_MAX        = starflux_pkg::X_MAX,
  parameter int                  SHIP_W       = 8,
  parameter int                  X_START      = 76,
  parameter int                  Y_START      = 110,
  parameter int                  STEP         = 2,
  parameter logic [HEALTH_W-1:0] HEALTH_INIT  = starflux_pkg::HEALTH_INIT,
  parameter int                  INVULN_TICKS = 4,
  parameter logic [27:0]         LED_DIV      = 28'd12500000
) (
  input  logic            clk,
  input  logic            resetn,
  ship_datapath_if.slave  bus
);

  localparam logic [7:0] X_START8 = 8'(X_START);
  localparam logic [6:0] Y_START7 = 7'(Y_START);
  localparam logic [7:0] STEP8    = 8'(STEP);
  localparam logic [8:0] X_LIM9   = 9'(X_MAX - SHIP_W + 1);
  localparam logic [7:0] INV_LOAD = 8'(INVULN_TICKS);

  ship_mode_t          state_q, state_d;
  logic [7:0]          x_q, x_d;
  logic [6:0]          y_q, y_d;
  logic [HEALTH_W-1:0] hp_q, hp_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                pend_q, pend_d;
  logic                fire_req_q, fire_req_d;
  logic                invuln_q;
  logic [7:0]          led_q, led_d;
  logic                upd_d, fire_d;
  logic                upd, fire_edge, led_tick;
  logic [8:0]          x_sum;
  logic [27:0]         div_q;

  rate_divider #(.WIDTH(28)) u_led_div (
    .clk             (clk),
    .resetn          (resetn),
    .enable          (bus.gameOverEn),
    .countdown_start (LED_DIV),
    .q               (div_q)
  );

  assign led_tick  = (div_q == '0);
  assign upd       = bus.shipUpdateEn & ~upd_d;
  assign fire_edge = bus.btn_fire & ~fire_d;
  // 9-bit sum so a right move near the edge clamps instead of wrapping
  assign x_sum     = {1'b0, x_q} + {1'b0, STEP8};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      x_q        <= X_START8;
      y_q        <= Y_START7;
      hp_q       <= HEALTH_INIT;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      fire_req_q <= 1'b0;
      invuln_q   <= 1'b0;
      led_q      <= '0;
      upd_d      <= 1'b0;
      fire_d     <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      hp_q       <= hp_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      fire_req_q <= fire_req_d;
      invuln_q   <= (cnt_d != '0);
      led_q      <= led_d;
      upd_d      <= bus.shipUpdateEn;
      fire_d     <= bus.btn_fire;
    end
  end

  // Start has priority over everything; updates only act in S_PLAY.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    hp_d       = hp_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    fire_req_d = 1'b0;
    led_d      = led_q;

    if (bus.startGameEn) begin
      state_d = S_PLAY;
      x_d     = X_START8;
      y_d     = Y_START7;
      hp_d    = HEALTH_INIT;
      cnt_d   = '0;
      pend_d  = 1'b0;
      led_d   = '0;
    end else begin
      if (state_q == S_PLAY) begin
        if (fire_edge)
          pend_d = 1'b1;
        if (upd) begin
          if (bus.btn_left && !bus.btn_right)
            x_d = (x_q < STEP8) ? 8'd0 : x_q - STEP8;
          else if (bus.btn_right && !bus.btn_left)
            x_d = (x_sum > X_LIM9) ? X_LIM9[7:0] : x_sum[7:0];

          if (bus.hit && cnt_q == '0) begin
            hp_d  = (hp_q == '0) ? '0 : hp_q - 1'b1;
            cnt_d = INV_LOAD;
          end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end

          // A fresh press landing on the consuming update stays queued
          if (pend_q) begin
            fire_req_d = 1'b1;
            if (!fire_edge)
              pend_d = 1'b0;
          end

          if (hp_d == '0)
            state_d = S_DEAD;
        end
      end

      if (bus.gameOverEn) begin
        if (led_q == '0)
          led_d = 8'b0000_0001;
        else if (led_tick)
          led_d = {led_q[6:0], led_q[7]};
      end
    end
  end

  assign bus.ship_x      = x_q;
  assign bus.ship_y      = y_q;
  assign bus.ship_health = hp_q;
  assign bus.fire_req    = fire_req_q;
  assign bus.invuln      = invuln_q;
  assign bus.led_pattern = led_q;

endmodule

// File: tb/tb_ship_datapath.sv
// tb_ship_datapath
// Directed bench for ship_datapath. Instance a uses default placement;
// instance b starts at column 1 to exercise the left clamp. Both see the
// same stimulus. LED divider shortened to 4.
module tb_ship_datapath;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #10 clk = ~clk;

  ship_datapath_if aif ();
  ship_datapath_if bif ();

  assign bif.startGameEn  = aif.startGameEn;
  assign bif.shipUpdateEn = aif.shipUpdateEn;
  assign bif.gameOverEn   = aif.gameOverEn;
  assign bif.btn_left     = aif.btn_left;
  assign bif.btn_right    = aif.btn_right;
  assign bif.btn_fire     = aif.btn_fire;
  assign bif.hit          = aif.hit;

  ship_datapath #(.LED_DIV(28'd4)) dut_a (
    .clk    (clk),
    .resetn (resetn),
    .bus    (aif)
  );

  ship_datapath #(.X_START(1), .LED_DIV(28'd4)) dut_b (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bif)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    aif.startGameEn = 1'b1;
    tick(1);
    aif.startGameEn = 1'b0;
  endtask

  task automatic do_update(input int len);
    aif.shipUpdateEn = 1'b1;
    tick(len);
    aif.shipUpdateEn = 1'b0;
    tick(1);
  endtask

  task automatic test_reset();
    aif.startGameEn = 0; aif.shipUpdateEn = 0; aif.gameOverEn = 0;
    aif.btn_left = 0; aif.btn_right = 0; aif.btn_fire = 0; aif.hit = 0;
    resetn = 1'b0;
    tick(2);
    resetn = 1'b1;
    tick(1);
    vectors++; if (aif.ship_x !== 8'd76) begin miscompares++; $display("[TB] FAIL reset_x got %0d want 76", aif.ship_x); end
    vectors++; if (aif.ship_y !== 7'd110) begin miscompares++; $display("[TB] FAIL reset_y got %0d want 110", aif.ship_y); end
    vectors++; if (aif.ship_health !== 8'd5) begin miscompares++; $display("[TB] FAIL reset_health got %0d want 5", aif.ship_health); end
    vectors++; if (aif.led_pattern !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_led got %h want 00", aif.led_pattern); end
    vectors++; if (aif.fire_req !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_fire got %b want 0", aif.fire_req); end
    vectors++; if (aif.invuln !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_invuln got %b want 0", aif.invuln); end
    vectors++; if (bif.ship_x !== 8'd1) begin miscompares++; $display("[TB] FAIL reset_x_b got %0d want 1", bif.ship_x); end
  endtask

  task automatic test_idle_update();
    aif.btn_right = 1'b1;
    aif.hit = 1'b1;
    do_update(5);
    aif.btn_right = 1'b0;
    aif.hit = 1'b0;
    vectors++; if (aif.ship_x !== 8'd76) begin miscompares++; $display("[TB] FAIL idle_move got %0d want 76", aif.ship_x); end
    vectors++; if (aif.ship_health !== 8'd5) begin miscompares++; $display("[TB] FAIL idle_health got %0d want 5", aif.ship_health); end
  endtask

  task automatic test_start_with_update();
    aif.btn_right = 1'b1;
    aif.hit = 1'b1;
    aif.startGameEn = 1'b1;
    aif.shipUpdateEn = 1'b1;
    tick(1);
    aif.startGameEn = 1'b0;
    vectors++; if (aif.ship_x !== 8'd76) begin miscompares++; $display("[TB] FAIL start_upd_x got %0d want 76", aif.ship_x); end
    vectors++; if (aif.ship_health !== 8'd5) begin miscompares++; $display("[TB] FAIL start_upd_health got %0d want 5", aif.ship_health); end
    tick(3);
    aif.shipUpdateEn = 1'b0;
    tick(1);
    vectors++; if (aif.ship_x !== 8'd76) begin miscompares++; $display("[TB] FAIL start_upd_hold got %0d want 76", aif.ship_x); end
    aif.btn_right = 1'b0;
    aif.hit = 1'b0;
  endtask

  task automatic test_move_right();
    int expx;
    do_start();
    aif.btn_right = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      do_update(100);
      expx = (76 + 2 * k > 152) ? 152 : 76 + 2 * k;
      vectors++;
      if (aif.ship_x !== 8'(expx)) begin
        miscompares++;
        $display("[TB] FAIL move_right_%0d got %0d want %0d", k, aif.ship_x, expx);
      end
    end
    aif.btn_right = 1'b0;
    vectors++; if (aif.ship_y !== 7'd110) begin miscompares++; $display("[TB] FAIL move_y got %0d want 110", aif.ship_y); end
  endtask

  task automatic test_left_clamp();
    do_start();
    aif.btn_left = 1'b1;
    do_update(3);
    vectors++; if (aif.ship_x !== 8'd74) begin miscompares++; $display("[TB] FAIL left_a1 got %0d want 74", aif.ship_x); end
    vectors++; if (bif.ship_x !== 8'd0) begin miscompares++; $display("[TB] FAIL left_clamp_b1 got %0d want 0", bif.ship_x); end
    do_update(3);
    vectors++; if (aif.ship_x !== 8'd72) begin miscompares++; $display("[TB] FAIL left_a2 got %0d want 72", aif.ship_x); end
    vectors++; if (bif.ship_x !== 8'd0) begin miscompares++; $display("[TB] FAIL left_clamp_b2 got %0d want 0", bif.ship_x); end
    aif.btn_right = 1'b1;
    do_update(3);
    vectors++; if (aif.ship_x !== 8'd72) begin miscompares++; $display("[TB] FAIL both_buttons got %0d want 72", aif.ship_x); end
    aif.btn_left = 1'b0;
    aif.btn_right = 1'b0;
  endtask

  task automatic test_damage();
    logic [7:0] exp_hp [10];
    logic       exp_inv [10];
    exp_hp  = '{8'd4, 8'd4, 8'd4, 8'd4, 8'd4, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3};
    exp_inv = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    do_start();
    aif.hit = 1'b1;
    for (int u = 0; u < 10; u++) begin
      do_update(4);
      vectors++;
      if (aif.ship_health !== exp_hp[u]) begin
        miscompares++;
        $display("[TB] FAIL damage_health_%0d got %0d want %0d", u + 1, aif.ship_health, exp_hp[u]);
      end
      vectors++;
      if (aif.invuln !== exp_inv[u]) begin
        miscompares++;
        $display("[TB] FAIL damage_invuln_%0d got %b want %b", u + 1, aif.invuln, exp_inv[u]);
      end
    end
  endtask

  // Continues from health 3 with counter 0 and hit still held
  task automatic test_death();
    for (int u = 0; u < 10; u++) do_update(4);
    vectors++; if (aif.ship_health !== 8'd1) begin miscompares++; $display("[TB] FAIL death_pre got %0d want 1", aif.ship_health); end
    do_update(4);
    vectors++; if (aif.ship_health !== 8'd0) begin miscompares++; $display("[TB] FAIL death_health got %0d want 0", aif.ship_health); end
    aif.btn_right = 1'b1;
    for (int u = 0; u < 6; u++) do_update(4);
    vectors++; if (aif.ship_x !== 8'd76) begin miscompares++; $display("[TB] FAIL dead_no_move got %0d want 76", aif.ship_x); end
    vectors++; if (aif.ship_health !== 8'd0) begin miscompares++; $display("[TB] FAIL dead_health_hold got %0d want 0", aif.ship_health); end
    aif.btn_right = 1'b0;
    aif.hit = 1'b0;
    do_start();
    vectors++; if (aif.ship_health !== 8'd5) begin miscompares++; $display("[TB] FAIL restart_health got %0d want 5", aif.ship_health); end
    aif.btn_right = 1'b1;
    do_update(3);
    aif.btn_right = 1'b0;
    vectors++; if (aif.ship_x !== 8'd78) begin miscompares++; $display("[TB] FAIL restart_move got %0d want 78", aif.ship_x); end
  endtask

  task automatic test_fire();
    do_start();
    aif.btn_fire = 1'b1;
    tick(1);
    aif.btn_fire = 1'b0;
    tick(2);
    vectors++; if (aif.fire_req !== 1'b0) begin miscompares++; $display("[TB] FAIL fire_early got %b want 0", aif.fire_req); end
    aif.shipUpdateEn = 1'b1;
    tick(1);
    vectors++; if (aif.fire_req !== 1'b1) begin miscompares++; $display("[TB] FAIL fire_pulse got %b want 1", aif.fire_req); end
    tick(1);
    vectors++; if (aif.fire_req !== 1'b0) begin miscompares++; $display("[TB] FAIL fire_width got %b want 0", aif.fire_req); end
    tick(3);
    aif.shipUpdateEn = 1'b0;
    tick(1);
    aif.shipUpdateEn = 1'b1;
    tick(1);
    vectors++; if (aif.fire_req !== 1'b0) begin miscompares++; $display("[TB] FAIL fire_consumed got %b want 0", aif.fire_req); end
    aif.shipUpdateEn = 1'b0;
    tick(1);
    // queue a shot, then press again on the same cycle as the consuming update
    aif.btn_fire = 1'b1;
    tick(1);
    aif.btn_fire = 1'b0;
    tick(1);
    aif.btn_fire = 1'b1;
    aif.shipUpdateEn = 1'b1;
    tick(1);
    vectors++; if (aif.fire_req !== 1'b1) begin miscompares++; $display("[TB] FAIL fire_same_cycle got %b want 1", aif.fire_req); end
    aif.btn_fire = 1'b0;
    tick(2);
    aif.shipUpdateEn = 1'b0;
    tick(1);
    aif.shipUpdateEn = 1'b1;
    tick(1);
    vectors++; if (aif.fire_req !== 1'b1) begin miscompares++; $display("[TB] FAIL fire_requeued got %b want 1", aif.fire_req); end
    tick(1);
    vectors++; if (aif.fire_req !== 1'b0) begin miscompares++; $display("[TB] FAIL fire_requeued_width got %b want 0", aif.fire_req); end
    aif.shipUpdateEn = 1'b0;
    tick(1);
  endtask

  task automatic test_leds();
    logic [7:0] exp;
    aif.gameOverEn = 1'b1;
    tick(1);
    exp = 8'h01;
    vectors++; if (aif.led_pattern !== exp) begin miscompares++; $display("[TB] FAIL led_load got %h want %h", aif.led_pattern, exp); end
    tick(3);
    vectors++; if (aif.led_pattern !== exp) begin miscompares++; $display("[TB] FAIL led_wait got %h want %h", aif.led_pattern, exp); end
    tick(1);
    exp = 8'h02;
    vectors++; if (aif.led_pattern !== exp) begin miscompares++; $display("[TB] FAIL led_first_step got %h want %h", aif.led_pattern, exp); end
    for (int i = 0; i < 8; i++) begin
      tick(4);
      vectors++; if (aif.led_pattern !== exp) begin miscompares++; $display("[TB] FAIL led_hold_%0d got %h want %h", i, aif.led_pattern, exp); end
      tick(1);
      exp = {exp[6:0], exp[7]};
      vectors++; if (aif.led_pattern !== exp) begin miscompares++; $display("[TB] FAIL led_step_%0d got %h want %h", i, aif.led_pattern, exp); end
    end
    aif.gameOverEn = 1'b0;
    tick(10);
    vectors++; if (aif.led_pattern !== exp) begin miscompares++; $display("[TB] FAIL led_disabled_hold got %h want %h", aif.led_pattern, exp); end
    do_start();
    vectors++; if (aif.led_pattern !== 8'h00) begin miscompares++; $display("[TB] FAIL led_start_clear got %h want 00", aif.led_pattern); end
  endtask

  task automatic test_reset_mid_update();
    do_start();
    aif.btn_right = 1'b1;
    aif.shipUpdateEn = 1'b1;
    tick(1);
    vectors++; if (aif.ship_x !== 8'd78) begin miscompares++; $display("[TB] FAIL mid_upd_move got %0d want 78", aif.ship_x); end
    tick(2);
    resetn = 1'b0;
    tick(1);
    vectors++; if (aif.ship_x !== 8'd76) begin miscompares++; $display("[TB] FAIL mid_reset_x got %0d want 76", aif.ship_x); end
    vectors++; if (aif.ship_health !== 8'd5) begin miscompares++; $display("[TB] FAIL mid_reset_health got %0d want 5", aif.ship_health); end
    resetn = 1'b1;
    tick(3);
    aif.shipUpdateEn = 1'b0;
    tick(1);
    do_update(3);
    vectors++; if (aif.ship_x !== 8'd76) begin miscompares++; $display("[TB] FAIL post_reset_idle got %0d want 76", aif.ship_x); end
    aif.btn_right = 1'b0;
  endtask

  initial begin
    test_reset();
    test_idle_update();
    test_start_with_update();
    test_move_right();
    test_left_clamp();
    test_damage();
    test_death();
    test_fire();
    test_leds();
    test_reset_mid_update();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
